adpll_loop_filter: RTL and testbench
====================================

Name: adpll_loop_filter

Overview:
- Accumulate-and-dump PI loop filter for the ADPLL.
- Sits between the phase detector and the NCO/DDS.
- Consumes signed phase-error samples, sums each block of 2^NL samples, then updates a proportional-plus-integral frequency control word.
- That word drives the DDS `freq` input directly.

Parameters:
- EW, 10: phase-error sample width (signed).
- PW, 32: frequency-word width (signed), matches DDS phase width.
- NL, 4: log2 of dump length; dump length N = 2^NL; NL >= 2 required.
- KP_SHIFT, 8: proportional gain = 2^KP_SHIFT.
- KI_SHIFT, 4: integral gain = 2^KI_SHIFT.
- F0, 32'h0100_0000: centre frequency word.
- Constraint: EW+NL+max(KP_SHIFT,KI_SHIFT) <= PW-1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: sample-accept enable.
- err_valid, in, 1: err is valid this cycle.
- err, in, EW: signed phase-error sample.
- clr_integ, in, 1: synchronous clear of integrator and accumulator.
- freq_out, out, PW: signed frequency word to the DDS, registered.
- freq_valid, out, 1: one-cycle pulse when freq_out updates.

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - acc=0, cnt=0, state=IDLE, integ=0.
  - freq_out=F0, freq_valid=0.
  - Reset mid-block discards the partial sum.
- Sample accept: a sample is taken when err_valid & en.
  - acc (EW+NL signed) += sign-extended err; cnt (NL bits) increments.
- Dump: the Nth accepted sample (cnt == N-1) is the dump sample.
  - S = acc + err, registered; acc <= 0; cnt wraps to 0.
  - FSM IDLE->SUM.
- Independence: the accumulator never stalls or drops samples.
  - Samples arriving while the FSM is in SUM or OUT go into the next block.
  - NL >= 2 guarantees the next dump arrives >= 4 cycles later.
- FSM states: IDLE, SUM, OUT.
  - SUM (1 cycle):
    - prop <= sext(S) <<< KP_SHIFT.
    - integ <= sat(integ + (sext(S) <<< KI_SHIFT)).
    - Go to OUT.
  - OUT (1 cycle):
    - freq_out <= sat(F0 + integ + prop).
    - freq_valid <= 1.
    - Go to IDLE.
  - IDLE: freq_valid <= 0.
- Latency: freq_valid is high for exactly one cycle, beginning 3 clock edges after the edge that accepts the dump sample.
  - freq_out holds its value between updates.
- Arithmetic:
  - All sums are computed at PW+2 bits.
  - sat() clamps to [-2^(PW-1), 2^(PW-1)-1].
  - The integrator saturates independently; it never wraps.
- en=0:
  - Blocks sample acceptance only.
  - An in-flight SUM/OUT completes.
  - acc and cnt hold.
- clr_integ:
  - Sets integ<=0, acc<=0, cnt<=0; overrides a simultaneous accept or integ update.
  - If asserted in SUM: integ becomes 0 (not 0+S), prop is computed normally, and OUT still occurs.
  - A dump sample coinciding with clr_integ is discarded; the FSM stays IDLE.
  - freq_out is unchanged until the next OUT.
- rst has priority over clr_integ.

Test Plan:
- Reset:
  - Stimulus: assert rst 2 cycles.
  - Required: freq_out=0x01000000, freq_valid=0; no freq_valid pulse for 15 accepted samples thereafter.
- Constant +1:
  - Stimulus: err=+1 on 16 consecutive valid cycles.
  - Required: S=16, prop=4096, integ=256; freq_out=0x01001100, freq_valid pulse 3 edges after 16th sample.
  - Stimulus: second identical block.
  - Required: freq_out=0x01001200.
- Gaps and enable:
  - Stimulus: same 16 +1 samples with random err_valid gaps, plus err_valid=1 cycles with en=0 carrying err=+100.
  - Required: identical result 0x01001100; en=0 samples ignored.
- Negative full scale:
  - Stimulus: err=-512 x16.
  - Required: S=-8192, freq_out=0x00DE0000.
  - Stimulus: back-to-back blocks.
  - Required: no sample lost; second block gives 0x00DC0000.
- Saturation:
  - Stimulus: F0=0x7FFFFF00, err=+511 x16.
  - Required: freq_out=0x7FFFFFFF; repeated blocks hold 0x7FFFFFFF, no wrap.
  - Stimulus: then err=-512 blocks.
  - Required: freq_out decreases monotonically.
- Clear and reset mid-operation:
  - Stimulus: clr_integ during SUM of the second +1 block.
  - Required: freq_out=0x01001000 (integ=0, prop=4096).
  - Stimulus: rst after 7 samples, then 16 more samples.
  - Required: single pulse with freq_out=0x01001100.

Source files
------------

// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: accumulate-and-dump PI loop filter for the ADPLL.
// Sums blocks of 2^NL signed phase-error samples and, for every finished
// block, updates a proportional-plus-integral frequency word for the DDS.
//
// Handshake: a sample is taken on any rising clk edge where err_valid & en
// are both high; there is no back-pressure, so the accumulator never stalls
// or drops samples. freq_valid is a one-cycle pulse marking the cycle in
// which freq_out carries a newly computed word; freq_out holds otherwise.
module adpll_loop_filter #(
   parameter int             EW       = 10,
   parameter int             PW       = 32,
   parameter int             NL       = 4,
   parameter int             KP_SHIFT = 8,
   parameter int             KI_SHIFT = 4,
   parameter logic [PW-1:0]  F0       = 32'h0100_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 err_valid,
   input  logic signed [EW-1:0] err,
   input  logic                 clr_integ,
   output logic signed [PW-1:0] freq_out,
   output logic                 freq_valid,
   output logic [1:0]           state_dbg
);

   localparam int AW = EW + NL;   // block accumulator width
   localparam int SW = PW + 2;    // width of every intermediate sum

   localparam logic [NL-1:0]        CNT_LAST = '1;
   localparam logic signed [SW-1:0] SAT_MAX  = {{3{1'b0}}, {(PW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN  = {{3{1'b1}}, {(PW-1){1'b0}}};
   localparam logic signed [SW-1:0] F0_EXT   = {{2{F0[PW-1]}}, F0};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUM  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   sum_en;
   logic   out_en;

   logic signed [AW-1:0] acc;
   logic [NL-1:0]        cnt;
   logic signed [AW-1:0] s_reg;
   logic                 dump_pend;
   logic signed [SW-1:0] prop;
   logic signed [PW-1:0] integ;

   // Clamp a wide sum into the PW-bit signed range.
   function automatic logic signed [PW-1:0] sat(input logic signed [SW-1:0] x);
      if (x > SAT_MAX) begin
         return SAT_MAX[PW-1:0];
      end else if (x < SAT_MIN) begin
         return SAT_MIN[PW-1:0];
      end else begin
         return x[PW-1:0];
      end
   endfunction

   logic                 accept;
   logic signed [AW-1:0] err_ext;
   logic signed [AW-1:0] acc_sum;
   logic signed [SW-1:0] s_ext;
   logic signed [SW-1:0] integ_ext;
   logic signed [SW-1:0] integ_sum;
   logic signed [SW-1:0] freq_sum;

   assign accept    = err_valid & en;
   assign err_ext   = {{NL{err[EW-1]}}, err};
   assign acc_sum   = acc + err_ext;
   assign s_ext     = {{(SW-AW){s_reg[AW-1]}}, s_reg};
   assign integ_ext = {{2{integ[PW-1]}}, integ};
   assign integ_sum = integ_ext + (s_ext <<< KI_SHIFT);
   assign freq_sum  = F0_EXT + integ_ext + prop;
   assign state_dbg = state;

   // Block accumulator: sums accepted samples and hands each finished block
   // to the filter via s_reg/dump_pend. A clear discards the partial block
   // and any dump not yet picked up by the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         s_reg     <= '0;
         dump_pend <= 1'b0;
      end else if (clr_integ) begin
         acc       <= '0;
         cnt       <= '0;
         dump_pend <= 1'b0;
      end else begin
         if (state == IDLE && dump_pend) begin
            dump_pend <= 1'b0;
         end
         if (accept) begin
            if (cnt == CNT_LAST) begin
               s_reg     <= acc_sum;
               acc       <= '0;
               cnt       <= '0;
               dump_pend <= 1'b1;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and stage strobes: IDLE waits for a dump, SUM updates
   // the P and I terms, OUT publishes the new frequency word.
   always_comb begin
      state_next = state;
      sum_en     = 1'b0;
      out_en     = 1'b0;
      case (state)
         IDLE: begin
            if (dump_pend && !clr_integ) begin
               state_next = SUM;
            end
         end
         SUM: begin
            sum_en     = 1'b1;
            state_next = OUT;
         end
         OUT: begin
            out_en     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Proportional term and saturating integrator; a clear wins over the
   // integrator update but the proportional term is still computed.
   always_ff @(posedge clk) begin
      if (rst) begin
         prop  <= '0;
         integ <= '0;
      end else begin
         if (sum_en) begin
            prop <= s_ext <<< KP_SHIFT;
         end
         if (clr_integ) begin
            integ <= '0;
         end else if (sum_en) begin
            integ <= sat(integ_sum);
         end
      end
   end

   // Registered output word and its one-cycle update pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_out   <= F0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= out_en;
         if (out_en) begin
            freq_out <= sat(freq_sum);
         end
      end
   end

endmodule

// File: tb/tb_adpll_loop_filter.sv
// tb_adpll_loop_filter: directed and randomized checks of the ADPLL loop
// filter against a block-level arithmetic model. Two instances share the
// stimulus: one at the default centre frequency, one near positive full
// scale to exercise output saturation.
module tb_adpll_loop_filter;

   localparam int     N_BLK = 16;     // dump length 2^NL
   localparam longint KP    = 256;    // 2^KP_SHIFT
   localparam longint KI    = 16;     // 2^KI_SHIFT
   localparam longint F0M   = 64'h0000_0000_0100_0000;
   localparam longint F0S   = 64'h0000_0000_7FFF_FF00;
   localparam longint MAXV  = (longint'(1) <<< 31) - 1;
   localparam longint MINV  = -(longint'(1) <<< 31);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              err_valid = 1'b0;
   logic signed [9:0] err = '0;
   logic              clr_integ = 1'b0;

   logic signed [31:0] freq_out_m, freq_out_s;
   logic               freq_valid_m, freq_valid_s;
   logic [1:0]         state_dbg_m, state_dbg_s;

   adpll_loop_filter u_main (
      .clk(clk), .rst(rst), .en(en), .err_valid(err_valid), .err(err),
      .clr_integ(clr_integ), .freq_out(freq_out_m), .freq_valid(freq_valid_m),
      .state_dbg(state_dbg_m)
   );

   adpll_loop_filter #(.F0(32'h7FFF_FF00)) u_sat (
      .clk(clk), .rst(rst), .en(en), .err_valid(err_valid), .err(err),
      .clr_integ(clr_integ), .freq_out(freq_out_s), .freq_valid(freq_valid_s),
      .state_dbg(state_dbg_s)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses_m = 0;

   longint blk_sum, integ_m, cur_main, cur_sat;
   longint pend_prop, pend_main, pend_sat;
   int     blk_cnt, pend_due;
   bit     pend_active;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic longint satf(input longint x);
      if (x > MAXV) return MAXV;
      if (x < MINV) return MINV;
      return x;
   endfunction

   // ---------------- reference model ----------------
   task automatic model_reset();
      blk_sum = 0; blk_cnt = 0; integ_m = 0;
      cur_main = F0M; cur_sat = F0S; pend_active = 1'b0;
   endtask

   task automatic model_publish(input longint integ_v);
      pend_main = satf(F0M + integ_v + pend_prop);
      pend_sat  = satf(F0S + integ_v + pend_prop);
   endtask

   task automatic model_accept(input int e);
      blk_sum += e;
      blk_cnt++;
      if (blk_cnt == N_BLK) begin
         pend_prop = blk_sum * KP;
         integ_m   = satf(integ_m + blk_sum * KI);
         model_publish(integ_m);
         pend_active = 1'b1;
         pend_due    = cyc + 3;
         blk_sum = 0; blk_cnt = 0;
      end
   endtask

   // Clear seen at edge `cyc`: the block in progress is lost; a block whose
   // integrator update happens on this edge contributes only its P term.
   task automatic model_clr();
      blk_sum = 0; blk_cnt = 0; integ_m = 0;
      if (pend_active && cyc == pend_due - 1) begin
         model_publish(0);
      end else if (pend_active && cyc < pend_due - 1) begin
         pend_active = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      bit exp_v;
      @(posedge clk);
      #1;
      cyc++;
      exp_v = pend_active && (cyc == pend_due);
      if (exp_v) begin
         cur_main = pend_main;
         cur_sat  = pend_sat;
         pend_active = 1'b0;
      end
      if (freq_valid_m) pulses_m++;
      chk("valid_main", {31'd0, freq_valid_m}, {31'd0, exp_v});
      chk("freq_main", freq_out_m, cur_main[31:0]);
      chk("valid_sat", {31'd0, freq_valid_s}, {31'd0, exp_v});
      chk("freq_sat", freq_out_s, cur_sat[31:0]);
   endtask

   task automatic cycle(input bit v, input bit e_n, input int e, input bit c);
      err_valid = v; en = e_n; err = 10'(e); clr_integ = c;
      tick();
      if (c) model_clr();
      else if (v && e_n) model_accept(e);
      err_valid = 1'b0; clr_integ = 1'b0; err = 10'($urandom_range(0, 1023));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; err_valid = 1'b0; clr_integ = 1'b0;
      model_reset();
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic samples(input int n, input int e);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, e, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 0, 1'b0);
   endtask

   // Random idle / disabled-sample cycles between accepted samples.
   task automatic gaps(input int maxg, input bit with_en0);
      int g;
      g = $urandom_range(0, maxg);
      for (int i = 0; i < g; i++) begin
         if (with_en0 && $urandom_range(0, 1) == 1) cycle(1'b1, 1'b0, 100, 1'b0);
         else cycle(1'b0, 1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int p0;
      model_reset();

      // Reset, then constant +1 blocks
      do_reset(2);
      chk("reset_freq", freq_out_m, 32'h0100_0000);
      chk("reset_valid", {31'd0, freq_valid_m}, 32'd0);
      p0 = pulses_m;
      samples(15, 1);
      chk("no_pulse_15", pulses_m - p0, 32'd0);
      samples(1, 1);
      idle(4);
      chk("plus1_blk1", freq_out_m, 32'h0100_1100);
      samples(16, 1);
      idle(4);
      chk("plus1_blk2", freq_out_m, 32'h0100_1200);

      // Gaps and disabled samples carrying +100
      do_reset(2);
      for (int i = 0; i < 16; i++) begin
         gaps(3, 1'b1);
         cycle(1'b1, 1'b1, 1, 1'b0);
      end
      idle(4);
      chk("gaps_en0", freq_out_m, 32'h0100_1100);

      // Negative full scale, back-to-back blocks
      do_reset(2);
      p0 = pulses_m;
      samples(20, -512);
      chk("neg_blk1", freq_out_m, 32'h00DE_0000);
      samples(12, -512);
      idle(4);
      chk("neg_blk2", freq_out_m, 32'h00DC_0000);
      chk("neg_pulses", pulses_m - p0, 32'd2);

      // Clear during SUM of the second block
      do_reset(2);
      samples(16, 1);
      idle(4);
      chk("clr_blk1", freq_out_m, 32'h0100_1100);
      samples(16, 1);
      idle(1);
      cycle(1'b0, 1'b1, 0, 1'b1);
      idle(3);
      chk("clr_in_sum", freq_out_m, 32'h0100_1000);

      // Clear coinciding with the dump sample discards the block
      p0 = pulses_m;
      samples(15, 1);
      cycle(1'b1, 1'b1, 1, 1'b1);
      idle(5);
      chk("clr_dump_nopulse", pulses_m - p0, 32'd0);
      samples(16, 1);
      idle(4);
      chk("after_clr_dump", freq_out_m, 32'h0100_1100);

      // Reset mid-block
      samples(7, 1);
      do_reset(2);
      p0 = pulses_m;
      samples(16, 1);
      idle(4);
      chk("rst_mid_freq", freq_out_m, 32'h0100_1100);
      chk("rst_mid_pulses", pulses_m - p0, 32'd1);

      // Saturation near positive full scale, then recovery
      do_reset(2);
      for (int b = 0; b < 4; b++) begin
         samples(16, 511);
         idle(4);
         chk("sat_hold", freq_out_s, 32'h7FFF_FFFF);
      end
      for (int b = 0; b < 3; b++) begin
         samples(16, -512);
         idle(4);
         chk("sat_recover", freq_out_s, 32'h7FE5_FB00 - 32'(b) * 32'h0002_0000);
      end

      // Randomized blocks with gaps and disabled cycles
      do_reset(2);
      for (int k = 0; k < 5 * N_BLK; k++) begin
         gaps(2, 1'b1);
         cycle(1'b1, 1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
